fetch_sequencer: RTL and testbench

- Instruction-fetch controller that owns the next-PC decision and sequences instruction-memory reads.
- Drives the PC register's data input (o_pc_next). Issues one fetch request per instruction and handles the req/ack handshake with instruction memory.
- Applies branches, stalls, halt and resume.
- Sits between the core control logic and the PC register / instruction memory pair.

---
 rtl/fetch_sequencer.sv | 106 ++++++++++
 tb/tb_fetch_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction-fetch controller: next-PC selection and imem req/ack sequencing
module fetch_sequencer #(
    parameter int PC_BITS        = 8,
    parameter int INST_MEM_DEPTH = 128,
    parameter int RESET_VECTOR   = 0
) (
    input  logic               i_clk,
    input  logic               i_nrst,
    input  logic               i_start,
    input  logic               i_halt,
    input  logic               i_stall,
    input  logic               i_branch_valid,
    input  logic [PC_BITS-1:0] i_branch_target,
    output logic               o_imem_req,
    output logic [PC_BITS-1:0] o_imem_addr,
    input  logic               i_imem_ack,
    output logic [PC_BITS-1:0] o_pc_next,
    output logic               o_fetch_valid,
    output logic [PC_BITS-1:0] o_fetch_pc,
    output logic [1:0]         o_state,
    output logic               o_fault
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    localparam logic [PC_BITS:0]   DEPTH_EXT = (PC_BITS+1)'(INST_MEM_DEPTH);
    localparam logic [PC_BITS-1:0] PC_LAST   = PC_BITS'(INST_MEM_DEPTH - 1);
    localparam logic [PC_BITS-1:0] PC_RESET  = PC_BITS'(RESET_VECTOR);

    logic [1:0]         r_state;
    logic [PC_BITS-1:0] r_pc;
    logic               r_fetch_valid;
    logic [PC_BITS-1:0] r_fetch_pc;
    logic               r_fault;

    logic               w_req;
    logic               w_accept;
    logic               w_branch_illegal;
    logic [PC_BITS-1:0] w_pc_inc;
    logic [1:0]         w_state_nxt;
    logic [PC_BITS-1:0] w_pc_nxt;
    logic               w_fault_nxt;

    assign w_req    = (r_state == S_FETCH) && !i_stall;
    assign w_accept = w_req && i_imem_ack;

    // Extra top bit so targets at or above the depth are caught even when depth == 2**PC_BITS.
    assign w_branch_illegal = i_branch_valid && ({1'b0, i_branch_target} >= DEPTH_EXT);
    assign w_pc_inc         = (r_pc == PC_LAST) ? '0 : r_pc + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_fault_nxt = r_fault;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (w_branch_illegal) begin
                    w_state_nxt = S_FAULT;
                    w_fault_nxt = 1'b1;
                end else begin
                    if (i_branch_valid)  w_pc_nxt = i_branch_target;
                    else if (w_accept)   w_pc_nxt = w_pc_inc;
                    if (i_halt)          w_state_nxt = S_HALT;
                end
            end
            S_HALT: begin
                if (i_start && !i_halt) w_state_nxt = S_FETCH;
            end
            default: begin
                w_state_nxt = S_FAULT;
                w_fault_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state       <= S_IDLE;
            r_pc          <= PC_RESET;
            r_fetch_valid <= 1'b0;
            r_fetch_pc    <= '0;
            r_fault       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_fault       <= w_fault_nxt;
            r_fetch_valid <= w_accept;
            if (w_accept) r_fetch_pc <= r_pc;
        end
    end

    assign o_imem_req    = w_req;
    assign o_imem_addr   = r_pc;
    assign o_pc_next     = r_pc;
    assign o_fetch_valid = r_fetch_valid;
    assign o_fetch_pc    = r_fetch_pc;
    assign o_state       = r_state;
    assign o_fault       = r_fault;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer against a behavioural model
module tb_fetch_sequencer;

    localparam int DEPTH = 128;

    logic       i_clk = 1'b0;
    logic       i_nrst = 1'b1;
    logic       i_start = 1'b0;
    logic       i_halt = 1'b0;
    logic       i_stall = 1'b0;
    logic       i_branch_valid = 1'b0;
    logic [7:0] i_branch_target = 8'd0;
    logic       i_imem_ack = 1'b0;
    logic       o_imem_req;
    logic [7:0] o_imem_addr;
    logic [7:0] o_pc_next;
    logic       o_fetch_valid;
    logic [7:0] o_fetch_pc;
    logic [1:0] o_state;
    logic       o_fault;

    int checks = 0;
    int failures = 0;

    fetch_sequencer #(.PC_BITS(8), .INST_MEM_DEPTH(DEPTH), .RESET_VECTOR(0)) dut (
        .i_clk(i_clk), .i_nrst(i_nrst), .i_start(i_start), .i_halt(i_halt),
        .i_stall(i_stall), .i_branch_valid(i_branch_valid), .i_branch_target(i_branch_target),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_ack(i_imem_ack),
        .o_pc_next(o_pc_next), .o_fetch_valid(o_fetch_valid), .o_fetch_pc(o_fetch_pc),
        .o_state(o_state), .o_fault(o_fault)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: state as a number 0..3, pc as a plain integer modulo DEPTH.
    int m_state = 0;
    int m_pc = 0;
    int m_fv = 0;
    int m_fpc = 0;
    int m_fault = 0;

    always @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            m_state = 0; m_pc = 0; m_fv = 0; m_fpc = 0; m_fault = 0;
        end else begin
            int acc;
            acc = (m_state == 1 && !i_stall && i_imem_ack) ? 1 : 0;
            m_fv = acc;
            if (acc == 1) m_fpc = m_pc;
            if (m_state == 0) begin
                if (i_start) m_state = 1;
            end else if (m_state == 1) begin
                if (i_branch_valid && int'(i_branch_target) >= DEPTH) begin
                    m_state = 3; m_fault = 1;
                end else begin
                    if (i_branch_valid) m_pc = int'(i_branch_target);
                    else if (acc == 1)  m_pc = (m_pc + 1) % DEPTH;
                    if (i_halt) m_state = 2;
                end
            end else if (m_state == 2) begin
                if (i_start && !i_halt) m_state = 1;
            end
        end
    end

    always @(negedge i_clk) begin
        check("imem_req",    32'(o_imem_req),    32'((m_state == 1 && !i_stall) ? 1 : 0));
        check("imem_addr",   32'(o_imem_addr),   32'(m_pc));
        check("pc_next",     32'(o_pc_next),     32'(m_pc));
        check("fetch_valid", 32'(o_fetch_valid), 32'(m_fv));
        check("fetch_pc",    32'(o_fetch_pc),    32'(m_fpc));
        check("state",       32'(o_state),       32'(m_state));
        check("fault",       32'(o_fault),       32'(m_fault));
        check("pc_range",    32'((int'(o_pc_next) < DEPTH) ? 1 : 0), 32'd1);
    end

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    // Steers pc to a value without producing any fetch (stall suppresses the accept).
    task automatic jump_to(input logic [7:0] target);
        i_imem_ack = 1'b0; i_stall = 1'b1; i_branch_valid = 1'b1; i_branch_target = target;
        tick();
        i_stall = 1'b0; i_branch_valid = 1'b0;
    endtask

    task automatic do_reset();
        i_nrst = 1'b0;
        tick();
        tick();
        i_nrst = 1'b1;
    endtask

    initial begin
        int wrap_pcs [4];
        wrap_pcs[0] = 126; wrap_pcs[1] = 127; wrap_pcs[2] = 0; wrap_pcs[3] = 1;

        #1;
        do_reset();
        check("rst_state", 32'(o_state), 32'd0);
        check("rst_pc", 32'(o_pc_next), 32'd0);
        check("rst_req", 32'(o_imem_req), 32'd0);
        check("rst_fault", 32'(o_fault), 32'd0);

        // Sequential fetch from reset vector with ack tied high.
        i_imem_ack = 1'b1; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("seq_fv", 32'(o_fetch_valid), 32'd1);
            check("seq_fpc", 32'(o_fetch_pc), 32'(k));
            check("seq_pc", 32'(o_pc_next), 32'(k + 1));
        end

        // Wrap from 127 to 0.
        jump_to(8'd126);
        i_imem_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("wrap_fv", 32'(o_fetch_valid), 32'd1);
            check("wrap_fpc", 32'(o_fetch_pc), 32'(wrap_pcs[k]));
        end
        check("wrap_fault", 32'(o_fault), 32'd0);

        // Delayed ack with a stall in cycle 2.
        jump_to(8'd5);
        i_imem_ack = 1'b0;
        #1;
        check("dly_req_c1", 32'(o_imem_req), 32'd1);
        tick();
        i_stall = 1'b1;
        #1;
        check("dly_req_c2", 32'(o_imem_req), 32'd0);
        tick();
        i_stall = 1'b0; i_imem_ack = 1'b1;
        #1;
        check("dly_req_c3", 32'(o_imem_req), 32'd1);
        tick();
        i_imem_ack = 1'b0;
        check("dly_fv", 32'(o_fetch_valid), 32'd1);
        check("dly_fpc", 32'(o_fetch_pc), 32'd5);
        check("dly_pc", 32'(o_pc_next), 32'd6);
        tick();
        check("dly_fv_once", 32'(o_fetch_valid), 32'd0);

        // Branch with ack in the same cycle.
        jump_to(8'd10);
        i_branch_valid = 1'b1; i_branch_target = 8'd40; i_imem_ack = 1'b1;
        tick();
        i_branch_valid = 1'b0; i_imem_ack = 1'b0;
        check("br_ack_fv", 32'(o_fetch_valid), 32'd1);
        check("br_ack_fpc", 32'(o_fetch_pc), 32'd10);
        check("br_ack_addr", 32'(o_imem_addr), 32'd40);

        // Branch without ack: request redirected, no fetch for 10.
        jump_to(8'd10);
        i_branch_valid = 1'b1; i_branch_target = 8'd40;
        tick();
        i_branch_valid = 1'b0;
        check("br_nak_fv", 32'(o_fetch_valid), 32'd0);
        check("br_nak_addr", 32'(o_imem_addr), 32'd40);

        // Halt together with an accept at pc 7, then resume.
        jump_to(8'd7);
        i_halt = 1'b1; i_imem_ack = 1'b1;
        tick();
        i_halt = 1'b0; i_imem_ack = 1'b0;
        check("halt_fv", 32'(o_fetch_valid), 32'd1);
        check("halt_fpc", 32'(o_fetch_pc), 32'd7);
        check("halt_state", 32'(o_state), 32'd2);
        check("halt_pc", 32'(o_pc_next), 32'd8);
        i_start = 1'b1; i_halt = 1'b1;
        tick();
        check("halt_hold", 32'(o_state), 32'd2);
        i_halt = 1'b0;
        tick();
        i_start = 1'b0;
        check("resume_state", 32'(o_state), 32'd1);
        check("resume_addr", 32'(o_imem_addr), 32'd8);
        check("resume_req", 32'(o_imem_req), 32'd1);

        // Async reset mid-request, with an accepted fetch pending report.
        i_imem_ack = 1'b1;
        tick();
        #1;
        i_nrst = 1'b0;
        #1;
        check("arst_req", 32'(o_imem_req), 32'd0);
        check("arst_state", 32'(o_state), 32'd0);
        check("arst_fv", 32'(o_fetch_valid), 32'd0);
        check("arst_fpc", 32'(o_fetch_pc), 32'd0);
        check("arst_pc", 32'(o_pc_next), 32'd0);
        i_imem_ack = 1'b0;
        tick();
        i_nrst = 1'b1;

        // Illegal branch target: terminal fault.
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_branch_valid = 1'b1; i_branch_target = 8'd200; i_halt = 1'b1;
        tick();
        i_branch_valid = 1'b0; i_halt = 1'b0;
        check("flt_state", 32'(o_state), 32'd3);
        check("flt_fault", 32'(o_fault), 32'd1);
        i_start = 1'b1; i_imem_ack = 1'b1;
        tick();
        tick();
        i_start = 1'b0;
        check("flt_sticky", 32'(o_state), 32'd3);
        check("flt_req", 32'(o_imem_req), 32'd0);
        i_imem_ack = 1'b0;
        do_reset();
        check("flt_rst_state", 32'(o_state), 32'd0);
        check("flt_rst_fault", 32'(o_fault), 32'd0);
        check("flt_rst_pc", 32'(o_pc_next), 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
